// File: rtl/band_pkg.sv
// Shared definitions for the band tracker, the downstream comparator and their benches.
//   BAND_W     : default sample/band width
//   state_e    : window-accumulation state (EMPTY = no sample yet, ACCUM = partial window)
//   SAMPLE_MAX : all-ones at BAND_W (running-minimum seed)
//   SAMPLE_MIN : zero at BAND_W (running-maximum seed)
package band_pkg;

    localparam int BAND_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } state_e;

    localparam logic [BAND_W-1:0] SAMPLE_MAX = {BAND_W{1'b1}};
    localparam logic [BAND_W-1:0] SAMPLE_MIN = {BAND_W{1'b0}};

endpackage

// File: rtl/band_minmax_update.sv
// Combinational running max/min update for one unsigned sample.
//   run_max, run_min : current extremes of the window
//   sample           : new unsigned sample
//   first            : sample is the first of its window; it seeds both extremes
//   next_max/next_min: updated extremes (ties leave the extreme unchanged)
module band_minmax_update #(
    parameter int W = 8
) (
    input  logic [W-1:0] run_max,
    input  logic [W-1:0] run_min,
    input  logic [W-1:0] sample,
    input  logic         first,
    output logic [W-1:0] next_max,
    output logic [W-1:0] next_min
);

    always_comb begin
        next_max = run_max;
        next_min = run_min;
        if (first) begin
            next_max = sample;
            next_min = sample;
        end else begin
            if (sample > run_max) next_max = sample;
            if (sample < run_min) next_min = sample;
        end
    end

endmodule

// File: rtl/band_window_tracker.sv
// Tracks running max/min of unsigned samples over windows of WINDOW accepted
// samples and publishes a registered (amax, amin) pair with a one-cycle strobe.
//   clk, rst   : clock and synchronous active-high reset
//   clear      : aborts the current window, keeps the published band
//   in_valid   : sample qualifier; in_data is the unsigned sample
//   in_ready   : high when a valid sample would be accepted (!rst && !clear)
//   amax, amin : published window extremes (amax >= amin once band_seen)
//   band_valid : one-cycle strobe when amax/amin take new values
//   band_seen  : sticky, set by the first publish after reset
//   count      : samples accepted in the current window
module band_window_tracker #(
    parameter int W      = 8,
    parameter int WINDOW = 16,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic [W-1:0]  amax,
    output logic [W-1:0]  amin,
    output logic          band_valid,
    output logic          band_seen,
    output logic [CW-1:0] count
);
    import band_pkg::*;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  run_max_q, run_max_d;
    logic [W-1:0]  run_min_q, run_min_d;
    logic [W-1:0]  amax_q, amax_d;
    logic [W-1:0]  amin_q, amin_d;
    logic          band_valid_q, band_valid_d;
    logic          band_seen_q, band_seen_d;

    logic          accept;
    logic          first;
    logic [CW-1:0] count_inc;
    logic [W-1:0]  next_max, next_min;

    assign in_ready = !rst && !clear;
    assign accept   = in_valid && in_ready;
    assign first    = (state_q == EMPTY);
    // The first sample of a window starts the count at 1 regardless of count_q.
    assign count_inc = first ? CW'(1) : count_q + CW'(1);

    band_minmax_update #(.W(W)) u_minmax (
        .run_max  (run_max_q),
        .run_min  (run_min_q),
        .sample   (in_data),
        .first    (first),
        .next_max (next_max),
        .next_min (next_min)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        run_max_d    = run_max_q;
        run_min_d    = run_min_q;
        amax_d       = amax_q;
        amin_d       = amin_q;
        band_valid_d = 1'b0;
        band_seen_d  = band_seen_q;

        if (clear) begin
            state_d   = EMPTY;
            count_d   = '0;
            run_max_d = '0;
            run_min_d = '1;
        end else if (accept) begin
            if (count_inc == CW'(WINDOW)) begin
                // Window complete: publish extremes including this sample and
                // re-seed so the next accepted sample starts a fresh window.
                amax_d       = next_max;
                amin_d       = next_min;
                band_valid_d = 1'b1;
                band_seen_d  = 1'b1;
                count_d      = '0;
                run_max_d    = '0;
                run_min_d    = '1;
                state_d      = EMPTY;
            end else begin
                run_max_d = next_max;
                run_min_d = next_min;
                count_d   = count_inc;
                state_d   = ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            count_q      <= '0;
            run_max_q    <= '0;
            run_min_q    <= '1;
            amax_q       <= '0;
            amin_q       <= '0;
            band_valid_q <= 1'b0;
            band_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            run_max_q    <= run_max_d;
            run_min_q    <= run_min_d;
            amax_q       <= amax_d;
            amin_q       <= amin_d;
            band_valid_q <= band_valid_d;
            band_seen_q  <= band_seen_d;
        end
    end

    assign amax       = amax_q;
    assign amin       = amin_q;
    assign band_valid = band_valid_q;
    assign band_seen  = band_seen_q;
    assign count      = count_q;

endmodule

// File: tb/tb_band_window_tracker.sv
module tb_band_window_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;

    // Instance a: WINDOW=4, instance b: WINDOW=1; both share the stimulus.
    logic        a_ready, a_bv, a_seen;
    logic [7:0]  a_amax, a_amin;
    logic [15:0] a_count;
    logic        b_ready, b_bv, b_seen;
    logic [7:0]  b_amax, b_amin;
    logic [15:0] b_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per instance, the list of samples of the open window.
    int win  [2] = '{4, 1};
    int samp [2][16];
    int n    [2];
    int m_amax [2];
    int m_amin [2];
    int m_bv   [2];
    int m_seen [2];

    always #5 clk = ~clk;

    band_window_tracker #(.W(8), .WINDOW(4), .CW(16)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_ready), .amax(a_amax), .amin(a_amin), .band_valid(a_bv),
        .band_seen(a_seen), .count(a_count)
    );

    band_window_tracker #(.W(8), .WINDOW(1), .CW(16)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_ready), .amax(b_amax), .amin(b_amin), .band_valid(b_bv),
        .band_seen(b_seen), .count(b_count)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int mx, mn;
        m_bv[k] = 0;
        if (rst) begin
            n[k] = 0; m_amax[k] = 0; m_amin[k] = 0; m_seen[k] = 0;
        end else if (clear) begin
            n[k] = 0;
        end else if (in_valid) begin
            samp[k][n[k]] = int'(in_data);
            n[k]++;
            if (n[k] == win[k]) begin
                mx = 0; mn = 255;
                for (int i = 0; i < n[k]; i++) begin
                    if (samp[k][i] > mx) mx = samp[k][i];
                    if (samp[k][i] < mn) mn = samp[k][i];
                end
                m_amax[k] = mx; m_amin[k] = mn;
                m_bv[k] = 1; m_seen[k] = 1; n[k] = 0;
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge.
    task automatic cyc(input logic r, input logic c, input logic v, input logic [7:0] d);
        rst = r; clear = c; in_valid = v; in_data = d;
        #1;
        check_eq("ready_a", int'(a_ready), int'(!r && !c));
        check_eq("ready_b", int'(b_ready), int'(!r && !c));
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_eq("amax_a",  int'(a_amax),  m_amax[0]);
        check_eq("amin_a",  int'(a_amin),  m_amin[0]);
        check_eq("bv_a",    int'(a_bv),    m_bv[0]);
        check_eq("seen_a",  int'(a_seen),  m_seen[0]);
        check_eq("count_a", int'(a_count), n[0]);
        check_eq("amax_b",  int'(b_amax),  m_amax[1]);
        check_eq("amin_b",  int'(b_amin),  m_amin[1]);
        check_eq("bv_b",    int'(b_bv),    m_bv[1]);
        check_eq("seen_b",  int'(b_seen),  m_seen[1]);
        check_eq("count_b", int'(b_count), n[1]);
        if (a_seen) check_eq("order_a", int'(a_amax >= a_amin), 1);
        if (b_seen) check_eq("order_b", int'(b_amax >= b_amin), 1);
    endtask

    task automatic feed4(input int s0, input int s1, input int s2, input int s3, input int gap);
        int s [4];
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'(s[i]));
            if (i < 3) for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, 8'(s[i]));
        end
    endtask

    initial begin
        n = '{0, 0};
        m_amax = '{0, 0}; m_amin = '{0, 0}; m_bv = '{0, 0}; m_seen = '{0, 0};
        @(posedge clk);
        #1;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 8'd0);
        cyc(1'b1, 1'b0, 1'b1, 8'd33);
        check_eq("rst_amax", int'(a_amax), 0);
        check_eq("rst_seen", int'(a_seen), 0);
        check_eq("rst_count", int'(a_count), 0);

        // Basic window
        feed4(50, 200, 100, 150, 0);
        check_eq("basic_bv", int'(a_bv), 1);
        check_eq("basic_amax", int'(a_amax), 200);
        check_eq("basic_amin", int'(a_amin), 50);
        check_eq("basic_count", int'(a_count), 0);
        check_eq("basic_seen", int'(a_seen), 1);
        cyc(1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("basic_bv_drop", int'(a_bv), 0);

        // Gapped input
        feed4(50, 200, 100, 150, 3);
        check_eq("gap_bv", int'(a_bv), 1);
        check_eq("gap_amax", int'(a_amax), 200);
        check_eq("gap_amin", int'(a_amin), 50);

        // Extremes and back-to-back windows
        feed4(0, 255, 255, 0, 0);
        check_eq("ext_amax", int'(a_amax), 255);
        check_eq("ext_amin", int'(a_amin), 0);
        feed4(100, 100, 100, 100, 0);
        check_eq("eq_amax", int'(a_amax), 100);
        check_eq("eq_amin", int'(a_amin), 100);
        feed4(10, 20, 30, 40, 0);
        check_eq("b2b1_amax", int'(a_amax), 40);
        check_eq("b2b1_amin", int'(a_amin), 10);
        feed4(5, 5, 5, 5, 0);
        check_eq("b2b2_bv", int'(a_bv), 1);
        check_eq("b2b2_amax", int'(a_amax), 5);
        check_eq("b2b2_amin", int'(a_amin), 5);

        // Clear mid-window
        cyc(1'b0, 1'b0, 1'b1, 8'd30);
        cyc(1'b0, 1'b0, 1'b1, 8'd40);
        cyc(1'b0, 1'b1, 1'b1, 8'd250);
        check_eq("clr_count", int'(a_count), 0);
        check_eq("clr_amax_held", int'(a_amax), 5);
        feed4(60, 70, 80, 90, 0);
        check_eq("clr_amax", int'(a_amax), 90);
        check_eq("clr_amin", int'(a_amin), 60);

        // Reset has priority over clear
        cyc(1'b0, 1'b0, 1'b1, 8'd30);
        cyc(1'b0, 1'b0, 1'b1, 8'd40);
        cyc(1'b1, 1'b1, 1'b1, 8'd77);
        check_eq("rp_seen", int'(a_seen), 0);
        check_eq("rp_amax", int'(a_amax), 0);
        check_eq("rp_count", int'(a_count), 0);
        feed4(12, 3, 44, 9, 0);
        check_eq("rp_win_amax", int'(a_amax), 44);
        check_eq("rp_win_amin", int'(a_amin), 3);

        // WINDOW=1 instance: strobe on consecutive cycles, band tracks sample
        cyc(1'b0, 1'b0, 1'b1, 8'd7);
        check_eq("w1_bv0", int'(b_bv), 1);
        check_eq("w1_amax0", int'(b_amax), 7);
        cyc(1'b0, 1'b0, 1'b1, 8'd3);
        check_eq("w1_bv1", int'(b_bv), 1);
        check_eq("w1_amin1", int'(b_amin), 3);
        cyc(1'b0, 1'b0, 1'b1, 8'd9);
        check_eq("w1_bv2", int'(b_bv), 1);
        check_eq("w1_amax2", int'(b_amax), 9);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic r, c, v;
            logic [7:0] d;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       d = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                default: d = 8'($urandom);
            endcase
            cyc(r, c, v, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
